// File: rtl/ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_clr
// Purpose  : Single-clock true dual-port RAM with a hardware clear sweep,
//            read-first same-port behaviour, cross-port write forwarding and
//            chip-enable output zero-masking (for OR-bus read muxing).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: RAM_PARITY_EN
//   defined   - each word stores an extra even-parity bit; O_PERRA/O_PERRB
//               flag a stored-parity mismatch on reads
//   undefined - storage is DW bits; O_PERRA/O_PERRB are tied to 0
// ----------------------------------------------------------------------------
// Ports:
//   I_CLK              clock for both ports
//   I_RESETn           asynchronous active-low reset
//   I_CLR              sweep request (pulse or level)
//   I_ADDRA/I_DA       port A address / write data
//   I_CEA/I_WEA        port A enable / write enable (qualified by I_CEA)
//   O_DA               port A read data (zero when masked)
//   I_ADDRB/I_DB       port B address / write data
//   I_CEB/I_WEB        port B enable / write enable (qualified by I_CEB)
//   O_DB               port B read data (zero when masked)
//   O_BUSY             clear sweep in progress
//   O_PERRA/O_PERRB    read parity error per port
// ============================================================================
module ram_dp_clr #(
  parameter int            AW         = 10,
  parameter int            DW         = 8,
  parameter logic [DW-1:0] CLR_VAL    = '0,
  parameter bit            CLR_ON_RST = 1'b1
) (
  input  logic          I_CLK,
  input  logic          I_RESETn,
  input  logic          I_CLR,
  input  logic [AW-1:0] I_ADDRA,
  input  logic [DW-1:0] I_DA,
  input  logic          I_CEA,
  input  logic          I_WEA,
  output logic [DW-1:0] O_DA,
  input  logic [AW-1:0] I_ADDRB,
  input  logic [DW-1:0] I_DB,
  input  logic          I_CEB,
  input  logic          I_WEB,
  output logic [DW-1:0] O_DB,
  output logic          O_BUSY,
  output logic          O_PERRA,
  output logic          O_PERRB
);

`ifdef RAM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  localparam int DEPTH = 1 << AW;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [MW-1:0]   mem [DEPTH];

  logic            idle;
  logic            same_addr;
  logic            wr_a;
  logic            wr_b;
  logic            fwd_a;
  logic            fwd_b;
  logic [MW-1:0]   rd_word_a;
  logic [MW-1:0]   rd_word_b;

  logic            ce_q_a;
  logic            ce_q_b;
  logic [DW-1:0]   dout_a;
  logic [DW-1:0]   dout_b;

  // Builds the stored word; with parity the top bit makes the word even.
  function automatic logic [MW-1:0] enc(input logic [DW-1:0] d);
`ifdef RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign idle      = (state == IDLE);
  assign same_addr = (I_ADDRA == I_ADDRB);
  assign wr_a      = I_CEA & I_WEA & idle;
  // On a same-address double write port A wins, so B's write is suppressed.
  assign wr_b      = I_CEB & I_WEB & idle & ~(wr_a & same_addr);
  // A pure read on one port sees the other port's write in the same cycle.
  assign fwd_a     = I_CEA & ~I_WEA & wr_b & same_addr;
  assign fwd_b     = I_CEB & ~I_WEB & wr_a & same_addr;
  assign rd_word_a = mem[I_ADDRA];
  assign rd_word_b = mem[I_ADDRB];

  // Sweep control. The reset value of state drives O_BUSY during reset.
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state <= CLR_ON_RST ? SWEEP : IDLE;
      cnt   <= '0;
    end else if (I_CLR) begin
      state <= SWEEP;
      cnt   <= '0;
    end else if (state == SWEEP) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        state <= IDLE;
      end
    end
  end

  // Storage. Writes are held off during reset so reset leaves contents intact.
  always_ff @(posedge I_CLK) begin
    if (I_RESETn) begin
      if (!idle) begin
        mem[cnt] <= enc(CLR_VAL);
      end
      if (wr_b) begin
        mem[I_ADDRB] <= enc(I_DB);
      end
      if (wr_a) begin
        mem[I_ADDRA] <= enc(I_DA);
      end
    end
  end

  // Read registers: data held while CE is low, only the mask flag follows CE.
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      ce_q_a <= 1'b0;
      ce_q_b <= 1'b0;
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      ce_q_a <= I_CEA;
      ce_q_b <= I_CEB;
      if (I_CEA) begin
        dout_a <= fwd_a ? I_DB : rd_word_a[DW-1:0];
      end
      if (I_CEB) begin
        dout_b <= fwd_b ? I_DA : rd_word_b[DW-1:0];
      end
    end
  end

  assign O_DA   = (ce_q_a && idle) ? dout_a : '0;
  assign O_DB   = (ce_q_b && idle) ? dout_b : '0;
  assign O_BUSY = (state == SWEEP);

`ifdef RAM_PARITY_EN
  logic perr_q_a;
  logic perr_q_b;

  // Odd word parity means the stored check bit disagrees with the data.
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      perr_q_a <= 1'b0;
      perr_q_b <= 1'b0;
    end else begin
      if (I_CEA) begin
        perr_q_a <= fwd_a ? 1'b0 : ^rd_word_a;
      end
      if (I_CEB) begin
        perr_q_b <= fwd_b ? 1'b0 : ^rd_word_b;
      end
    end
  end

  assign O_PERRA = ce_q_a & idle & perr_q_a;
  assign O_PERRB = ce_q_b & idle & perr_q_b;
`else
  assign O_PERRA = 1'b0;
  assign O_PERRB = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dp_clr
// Purpose  : Directed self-checking bench for ram_dp_clr (AW=4, DW=8,
//            CLR_VAL=8'h5A, CLR_ON_RST=1) with a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dp_clr;

  localparam int            AW  = 4;
  localparam int            DW  = 8;
  localparam logic [DW-1:0] CLR = 8'h5A;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;
  logic          ce_a, we_a, ce_b, we_b;
  logic [DW-1:0] dout_a, dout_b;
  logic          busy, perr_a, perr_b;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string         tag;
    bit            port;   // 0 = A, 1 = B
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb[$];

  ram_dp_clr #(
    .AW(AW), .DW(DW), .CLR_VAL(CLR), .CLR_ON_RST(1'b1)
  ) dut (
    .I_CLK(clk), .I_RESETn(rst_n), .I_CLR(clr),
    .I_ADDRA(addr_a), .I_DA(din_a), .I_CEA(ce_a), .I_WEA(we_a), .O_DA(dout_a),
    .I_ADDRB(addr_b), .I_DB(din_b), .I_CEB(ce_b), .I_WEB(we_b), .O_DB(dout_b),
    .O_BUSY(busy), .O_PERRA(perr_a), .O_PERRB(perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit port, input string tag, input logic [DW-1:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then every
  // read expected from the just-completed edge is compared.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, 32'(e.port ? dout_b : dout_a), 32'(e.exp));
    end
  endtask

  task automatic idle_ports();
    ce_a = 0; we_a = 0; ce_b = 0; we_b = 0; clr = 0;
  endtask

  int            n;
  int            bc;
  logic          exp_perr;

  initial begin
    rst_n = 0; clr = 0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    ce_a = 0; we_a = 0; ce_b = 0; we_b = 0;

    // Reset state
    repeat (3) begin
      @(posedge clk);
    end
    #1;
    check("rst_da", 32'(dout_a), 32'h0);
    check("rst_db", 32'(dout_b), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_perra", 32'(perr_a), 32'h0);
    check("rst_perrb", 32'(perr_b), 32'h0);

    // Sweep after reset release lasts 16 cycles
    rst_n = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 100);
    check("rst_sweep_len", 32'(n), 32'd16);

    // Every word reads back the clear value on both ports
    for (int i = 0; i < 16; i++) begin
      ce_a = 1; addr_a = AW'(i);
      ce_b = 1; addr_b = AW'(15 - i);
      push(0, $sformatf("clr_rd_a%0d", i), CLR);
      push(1, $sformatf("clr_rd_b%0d", 15 - i), CLR);
      tick();
    end

    // CE low masks the outputs
    idle_ports();
    push(0, "mask_a", 8'h00);
    push(1, "mask_b", 8'h00);
    tick();

    // A write @7 is read-first, then read back
    ce_a = 1; we_a = 1; addr_a = 4'd7; din_a = 8'h3C;
    push(0, "wr7_readfirst", CLR);
    tick();
    we_a = 0;
    push(0, "rd7", 8'h3C);
    tick();
    ce_a = 0;
    push(0, "rd7_masked", 8'h00);
    tick();

    // A writes @2 while B reads @2: B sees the new data
    ce_a = 1; we_a = 1; addr_a = 4'd2; din_a = 8'h11;
    ce_b = 1; we_b = 0; addr_b = 4'd2;
    push(0, "wr2_readfirst_a", CLR);
    push(1, "fwd_b", 8'h11);
    tick();
    we_a = 0;
    push(0, "rd2_a", 8'h11);
    push(1, "rd2_b", 8'h11);
    tick();

    // B writes @9 while A reads @9: symmetric forwarding
    ce_a = 1; we_a = 0; addr_a = 4'd9;
    ce_b = 1; we_b = 1; addr_b = 4'd9; din_b = 8'h77;
    push(0, "fwd_a", 8'h77);
    push(1, "wr9_readfirst_b", CLR);
    tick();

    // Both write @3: both read old, A's data wins
    ce_a = 1; we_a = 1; addr_a = 4'd3; din_a = 8'hAA;
    ce_b = 1; we_b = 1; addr_b = 4'd3; din_b = 8'hBB;
    push(0, "dual_wr_old_a", CLR);
    push(1, "dual_wr_old_b", CLR);
    tick();
    we_a = 0; we_b = 0;
    push(0, "dual_wr_rd_a", 8'hAA);
    push(1, "dual_wr_rd_b", 8'hAA);
    tick();
    idle_ports();
    tick();

    // Requested sweep, restarted at the 8th sweep cycle
    clr = 1;
    tick();
    clr = 0;
    check("clr_busy_rise", 32'(busy), 32'h1);
    bc = busy ? 1 : 0;
    n = 0;
    while (bc > 0 && n < 100) begin
      clr  = (bc == 8);
      ce_a = 1; we_a = 1; addr_a = AW'(bc); din_a = 8'h99;
      tick();
      n++;
      if (busy) begin
        bc++;
        check("sweep_da_zero", 32'(dout_a), 32'h0);
      end else begin
        break;
      end
    end
    idle_ports();
    check("restart_busy_len", 32'(bc), 32'd24);
    for (int i = 0; i < 16; i++) begin
      ce_a = 1; addr_a = AW'(i);
      push(0, $sformatf("post_sweep_rd%0d", i), CLR);
      tick();
    end
    idle_ports();

    // Reset in the middle of a sweep, then a full rerun
    clr = 1;
    tick();
    clr = 0;
    ce_a = 1; ce_b = 1; addr_a = 4'd3; addr_b = 4'd7;
    repeat (5) tick();
    rst_n = 0;
    #1;
    check("midrst_da", 32'(dout_a), 32'h0);
    check("midrst_db", 32'(dout_b), 32'h0);
    check("midrst_busy", 32'(busy), 32'h1);
    check("midrst_perra", 32'(perr_a), 32'h0);
    idle_ports();
    tick();
    tick();
    rst_n = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 100);
    check("rerun_sweep_len", 32'(n), 32'd16);
    ce_a = 1; addr_a = 4'd3;
    ce_b = 1; addr_b = 4'd7;
    push(0, "rerun_rd3", CLR);
    push(1, "rerun_rd7", CLR);
    tick();

    // Parity error on a corrupted word only
`ifdef RAM_PARITY_EN
    dut.mem[5][DW] = ~dut.mem[5][DW];
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    ce_b = 0;
    ce_a = 1; addr_a = 4'd5;
    push(0, "par_rd5", CLR);
    tick();
    check("perra_addr5", 32'(perr_a), 32'(exp_perr));
    addr_a = 4'd4;
    push(0, "par_rd4", CLR);
    tick();
    check("perra_addr4", 32'(perr_a), 32'h0);
    idle_ports();
    tick();
    check("perra_masked", 32'(perr_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
